writeback_stage: RTL

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: 2-entry result FIFO that drains register/vector/CC/PC writes to decode.
// Optional macro WB_BYPASS_EN lets a result skip the empty FIFO for zero queue latency.
module writeback_stage #(
  parameter int PC_WIDTH      = 16,
  parameter int OPCODE_WIDTH  = 8,
  parameter int REG_WIDTH     = 16,
  parameter int VREG_WIDTH    = 64,
  parameter int VREG_ID_WIDTH = 6
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET_N,
  input  logic                     I_LOCK,
  output logic                     O_LOCK,
  input  logic                     I_MW_Valid,
  input  logic [PC_WIDTH-1:0]      I_PC,
  input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
  input  logic [3:0]               I_DestRegIdx,
  input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
  input  logic                     I_RegWrite,
  input  logic                     I_VRegWrite,
  input  logic                     I_CCWrite,
  input  logic [REG_WIDTH-1:0]     I_Data,
  input  logic [VREG_WIDTH-1:0]    I_VecData,
  input  logic                     I_BrTaken,
  input  logic [PC_WIDTH-1:0]      I_BrTarget,
  input  logic                     I_GPUStallSignal,
  output logic                     O_WBFull,
  output logic                     O_RegWEn,
  output logic [3:0]               O_WriteBackRegIdx,
  output logic [REG_WIDTH-1:0]     O_WriteBackData,
  output logic                     O_VRegWEn,
  output logic [VREG_ID_WIDTH-1:0] O_WriteBackVRegIdx,
  output logic [VREG_WIDTH-1:0]    O_VecDestValue,
  output logic                     O_CCWEn,
  output logic [2:0]               O_CCValue,
  output logic                     O_WriteBackPCEn,
  output logic [PC_WIDTH-1:0]      O_WriteBackPC,
  output logic [3:0]               O_PendDestRegIdx,
  output logic                     O_PendDestWrite,
  output logic [VREG_ID_WIDTH-1:0] O_PendDestVRegIdx,
  output logic                     O_PendDestVWrite,
  output logic                     O_PendCCWEn
);

  typedef struct packed {
    logic [3:0]               dreg;
    logic [VREG_ID_WIDTH-1:0] dvreg;
    logic                     regw;
    logic                     vregw;
    logic                     ccw;
    logic                     brtaken;
    logic [REG_WIDTH-1:0]     data;
    logic [VREG_WIDTH-1:0]    vdata;
    logic [PC_WIDTH-1:0]      brtarget;
  } wb_entry_t;

  wb_entry_t  fifo [2];
  wb_entry_t  in_entry;
  wb_entry_t  head;
  wb_entry_t  older;
  wb_entry_t  younger;
  wb_entry_t  src;
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic       deq;
  logic       enq;
  logic       byp;
  logic       load;
  logic       unused_inputs;

  // PC and opcode travel with the result but are not needed at writeback.
  assign unused_inputs = ^{I_PC, I_Opcode};

  function automatic logic [2:0] cc_of(input logic [REG_WIDTH-1:0] d);
    if (d == '0)               return 3'b010;
    else if (d[REG_WIDTH-1])   return 3'b100;
    else                       return 3'b001;
  endfunction

  always_comb begin
    in_entry          = '0;
    in_entry.dreg     = I_DestRegIdx;
    in_entry.dvreg    = I_DestVRegIdx;
    in_entry.regw     = I_RegWrite;
    in_entry.vregw    = I_VRegWrite;
    in_entry.ccw      = I_CCWrite;
    in_entry.brtaken  = I_BrTaken;
    in_entry.data     = I_Data;
    in_entry.vdata    = I_VecData;
    in_entry.brtarget = I_BrTarget;
  end

`ifdef WB_BYPASS_EN
  assign byp = I_LOCK & I_MW_Valid & (count == 2'd0) & ~I_GPUStallSignal;
`else
  assign byp = 1'b0;
`endif

  assign head    = fifo[rd_ptr];
  assign older   = fifo[rd_ptr];
  assign younger = fifo[~wr_ptr];
  assign deq     = I_LOCK & (count != 2'd0) & ~I_GPUStallSignal;
  // A full FIFO still accepts when the head leaves on the same edge.
  assign enq     = I_LOCK & I_MW_Valid & ~byp & ((count != 2'd2) | deq);
  assign load    = deq | byp;
  assign src     = byp ? in_entry : head;
  assign O_WBFull = (count == 2'd2);

  always_ff @(posedge I_CLOCK) begin
    if (!I_RESET_N) begin
      count  <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (enq) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge I_CLOCK) begin
    if (I_RESET_N && enq) fifo[wr_ptr] <= in_entry;
  end

  always_ff @(posedge I_CLOCK) begin
    if (!I_RESET_N) begin
      O_LOCK             <= 1'b0;
      O_RegWEn           <= 1'b0;
      O_VRegWEn          <= 1'b0;
      O_CCWEn            <= 1'b0;
      O_WriteBackPCEn    <= 1'b0;
      O_WriteBackRegIdx  <= '0;
      O_WriteBackData    <= '0;
      O_WriteBackVRegIdx <= '0;
      O_VecDestValue     <= '0;
      O_CCValue          <= '0;
      O_WriteBackPC      <= '0;
    end else begin
      O_LOCK          <= I_LOCK;
      O_RegWEn        <= load & src.regw;
      O_VRegWEn       <= load & src.vregw;
      O_CCWEn         <= load & src.ccw;
      O_WriteBackPCEn <= load & src.brtaken;
      if (load) begin
        O_WriteBackRegIdx  <= src.dreg;
        O_WriteBackData    <= src.data;
        O_WriteBackVRegIdx <= src.dvreg;
        O_VecDestValue     <= src.vdata;
        O_CCValue          <= cc_of(src.data);
        O_WriteBackPC      <= src.brtarget;
      end
    end
  end

  // Oldest first so the youngest scalar/vector writer's index wins.
  always_comb begin
    O_PendDestWrite   = O_RegWEn;
    O_PendDestRegIdx  = O_RegWEn ? O_WriteBackRegIdx : 4'd0;
    O_PendDestVWrite  = O_VRegWEn;
    O_PendDestVRegIdx = O_VRegWEn ? O_WriteBackVRegIdx : '0;
    O_PendCCWEn       = O_CCWEn;
    if (count != 2'd0) begin
      if (older.regw) begin
        O_PendDestWrite  = 1'b1;
        O_PendDestRegIdx = older.dreg;
      end
      if (older.vregw) begin
        O_PendDestVWrite  = 1'b1;
        O_PendDestVRegIdx = older.dvreg;
      end
      if (younger.regw) begin
        O_PendDestWrite  = 1'b1;
        O_PendDestRegIdx = younger.dreg;
      end
      if (younger.vregw) begin
        O_PendDestVWrite  = 1'b1;
        O_PendDestVRegIdx = younger.dvreg;
      end
      O_PendCCWEn = O_PendCCWEn | older.ccw | younger.ccw;
    end
  end

endmodule
